product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, the number of products summed per result; legal range 1..255.
REQ-002 The block SHALL have parameter ACC_W, default 24, the accumulator and result width; legal range 16..32.
REQ-003 Port clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port clear  input  1  synchronous abort of the current accumulation and zeroing of the drop counter.
REQ-006 Port in_valid  input  1  product present on in_prod; a one-cycle pulse from the upstream sequential multiplier.
REQ-007 Port in_prod  input  16  unsigned product.
REQ-008 Port in_ready  output  1  block can accept a product this cycle.
REQ-009 Port out_valid  output  1  result available on out_sum/out_ovf.
REQ-010 Port out_ready  input  1  downstream accepts the result.
REQ-011 Port out_sum  output  ACC_W  unsigned saturated sum of N_TERMS products.
REQ-012 Port out_ovf  output  1  the result saturated.
REQ-013 Port drop_cnt  output  8  count of products lost while in_ready=0.

Function
REQ-014 An accept SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have states IDLE, ACC and HOLD; in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD, decoded combinationally from the state.
REQ-016 IDLE: an accept SHALL load acc with in_prod zero-extended and set cnt to 1, then go to ACC; if N_TERMS=1 it SHALL go straight to HOLD instead.
REQ-017 ACC: each accept SHALL add in_prod to acc and increment cnt; cycles without an accept SHALL hold acc and cnt.
REQ-018 The accept that brings cnt to N_TERMS SHALL register the final sum into out_sum, set out_valid=1 on the next edge and enter HOLD, giving a latency of 1 cycle from the last accept to out_valid.
REQ-019 Addition SHALL saturate: if a sum exceeds 2^ACC_W-1, acc SHALL become all ones, stay all ones for the rest of the group, and the group's out_ovf SHALL be 1.
REQ-020 HOLD: out_sum, out_ovf and out_valid SHALL stay stable until out_valid=1 and out_ready=1; on that edge out_valid SHALL go to 0, out_ovf to 0, acc and cnt to 0, and the state to IDLE.
REQ-021 The earliest accept of the next group SHALL be the cycle after the handshake; out_sum SHALL keep its last value while out_valid=0.
REQ-022 in_valid=1 with in_ready=0 SHALL increment drop_cnt, saturating at 255; the product SHALL be discarded.
REQ-023 clear=1 SHALL take priority over in_valid and out_ready: next state IDLE, acc=0, cnt=0, out_valid=0, out_ovf=0, drop_cnt=0; out_sum SHALL be unchanged.
REQ-024 in_valid with in_prod=0 SHALL be a normal accept and count toward N_TERMS.
REQ-025 The block SHALL contain no combinational path from in_valid to out_valid.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, acc=0, cnt=0, out_sum=0, out_valid=0, out_ovf=0 and drop_cnt=0; in_ready SHALL therefore read 1.
REQ-027 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result; the first accept after release SHALL start a new group with cnt=1.

Verification
REQ-028 N_TERMS=4, ACC_W=24, out_ready=1, products 0x0010, 0x0020, 0x0030, 0x0040 on non-consecutive cycles -> out_valid one cycle after the 4th, out_sum=0x0000A0, out_ovf=0.
REQ-029 N_TERMS=4, four products of 0xFFFF back-to-back -> out_sum=0x03FFFC, out_ovf=0.
REQ-030 N_TERMS=2, ACC_W=16, products 0xFFFF then 0x0001 -> out_sum=0xFFFF, out_ovf=1; the next group 0x0001, 0x0002 -> out_sum=0x0003, out_ovf=0.
REQ-031 Result pending, out_ready=0 for 5 cycles, 3 in_valid pulses -> in_ready=0, out_sum stable, drop_cnt=3; out_ready=1 -> out_valid=0 the next cycle, in_ready=1.
REQ-032 Two products accepted, then clear=1 together with in_valid -> no accept, drop_cnt=0; four more products -> out_sum equals only those four.
REQ-033 reset pulsed asynchronously between clock edges during HOLD -> all outputs 0 immediately; the next group sums correctly from cnt=1.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 16-bit products from a sequential multiplier into a
// saturating ACC_W-bit result, held until the downstream handshake completes.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       drop_cnt
);

  localparam logic [7:0] N_LAST = 8'(N_TERMS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ACC_W-1:0] acc_reg;
  logic [7:0]       cnt_reg;
  logic             grp_ovf_reg;
  logic [ACC_W-1:0] out_sum_reg;
  logic             out_valid_reg;
  logic             out_ovf_reg;
  logic [7:0]       drop_cnt_reg;

  logic             accept;
  logic             drop;
  logic             release_res;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic             grp_ovf_next;
  logic [7:0]       cnt_inc;
  logic             last_term;

  assign in_ready    = (state_reg != HOLD);
  assign accept      = in_valid && in_ready && !clear;
  assign drop        = in_valid && !in_ready && !clear;
  assign release_res = out_valid_reg && out_ready;

  // A group's first product loads rather than adds, so IDLE uses a zero base.
  assign acc_base     = (state_reg == IDLE) ? '0 : acc_reg;
  assign prod_ext     = {{(ACC_W-15){1'b0}}, in_prod};
  assign sum_wide     = {1'b0, acc_base} + prod_ext;
  assign sum_sat      = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
  assign grp_ovf_next = sum_wide[ACC_W] || ((state_reg != IDLE) && grp_ovf_reg);
  assign cnt_inc      = (state_reg == IDLE) ? 8'd1 : cnt_reg + 8'd1;
  assign last_term    = (cnt_inc == N_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = last_term ? HOLD : ACC;
        ACC:     if (accept && last_term) state_next = HOLD;
        HOLD:    if (release_res) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      grp_ovf_reg   <= 1'b0;
      out_sum_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
      drop_cnt_reg  <= '0;
    end else if (clear) begin
      // out_sum deliberately keeps the last delivered result.
      acc_reg       <= '0;
      cnt_reg       <= '0;
      grp_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      if (accept) begin
        acc_reg     <= sum_sat;
        cnt_reg     <= cnt_inc;
        grp_ovf_reg <= grp_ovf_next;
        if (last_term) begin
          out_sum_reg   <= sum_sat;
          out_ovf_reg   <= grp_ovf_next;
          out_valid_reg <= 1'b1;
        end
      end else if (release_res) begin
        acc_reg       <= '0;
        cnt_reg       <= '0;
        grp_ovf_reg   <= 1'b0;
        out_valid_reg <= 1'b0;
        out_ovf_reg   <= 1'b0;
      end
      if (drop && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  assign out_sum   = out_sum_reg;
  assign out_valid = out_valid_reg;
  assign out_ovf   = out_ovf_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: a 4-term/24-bit instance plus a 2-term/16-bit instance for
// the saturation vectors, both fed from the same stimulus.
module tb_product_accumulator;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_sum;
  logic        out_ovf;
  logic [7:0]  drop_cnt;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [15:0] b_out_sum;
  logic        b_out_ovf;
  logic [7:0]  b_drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  product_accumulator #(.N_TERMS(4), .ACC_W(24)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .drop_cnt(drop_cnt)
  );

  product_accumulator #(.N_TERMS(2), .ACC_W(16)) dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .drop_cnt(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One-cycle product pulse; returns on the negedge after the sampling edge.
  task automatic pulse(input logic [15:0] p);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic burst(input int n, input logic [15:0] p);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    #1 reset = 1'b1;
    #7;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Spaced products
    pulse(16'h0010);
    pulse(16'h0020);
    pulse(16'h0030);
    check("spaced_no_early_valid", 32'(out_valid), 32'd0);
    pulse(16'h0040);
    check("spaced_valid",    32'(out_valid), 32'd1);
    check("spaced_sum",      32'(out_sum),   32'h0000A0);
    check("spaced_ovf",      32'(out_ovf),   32'd0);
    check("spaced_in_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    check("spaced_release_valid", 32'(out_valid), 32'd0);
    check("spaced_release_ready", 32'(in_ready),  32'd1);
    check("spaced_sum_kept",      32'(out_sum),   32'h0000A0);

    // Back-to-back maximum products
    do_clear();
    burst(4, 16'hFFFF);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_sum",   32'(out_sum),   32'h03FFFC);
    check("b2b_ovf",   32'(out_ovf),   32'd0);

    // Saturation on the 16-bit, 2-term instance
    do_clear();
    check("clear_drop_b", 32'(b_drop_cnt), 32'd0);
    pulse(16'hFFFF);
    pulse(16'h0001);
    check("sat_valid_b", 32'(b_out_valid), 32'd1);
    check("sat_sum_b",   32'(b_out_sum),   32'h0000FFFF);
    check("sat_ovf_b",   32'(b_out_ovf),   32'd1);
    @(negedge clk);
    check("sat_release_ovf_b", 32'(b_out_ovf), 32'd0);
    pulse(16'h0001);
    pulse(16'h0002);
    check("next_sum_b", 32'(b_out_sum), 32'h00000003);
    check("next_ovf_b", 32'(b_out_ovf), 32'd0);
    check("mixed_sum",  32'(out_sum),   32'h010003);
    @(negedge clk);

    // Pending result with stalled downstream: drops counted
    do_clear();
    out_ready = 1'b0;
    pulse(16'h0001);
    pulse(16'h0002);
    pulse(16'h0003);
    pulse(16'h0004);
    check("stall_sum_pre", 32'(out_sum), 32'h00000A);
    pulse(16'h1111);
    pulse(16'h2222);
    pulse(16'h3333);
    check("stall_in_ready",  32'(in_ready),  32'd0);
    check("stall_valid",     32'(out_valid), 32'd1);
    check("stall_sum_kept",  32'(out_sum),   32'h00000A);
    check("stall_drop_cnt",  32'(drop_cnt),  32'd3);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready),  32'd1);
    check("stall_drop_kept",     32'(drop_cnt),  32'd3);

    // Clear aborts a partial group and wins over in_valid
    pulse(16'h0005);
    pulse(16'h0006);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 16'h0100;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_drop_cnt", 32'(drop_cnt),  32'd0);
    check("clear_valid",    32'(out_valid), 32'd0);
    pulse(16'h0007);
    pulse(16'h0008);
    pulse(16'h0009);
    check("clear_no_early_valid", 32'(out_valid), 32'd0);
    pulse(16'h000A);
    check("clear_valid_after", 32'(out_valid), 32'd1);
    check("clear_sum",         32'(out_sum),   32'h000022);
    @(negedge clk);

    // Asynchronous reset during HOLD, then a group containing a zero product
    out_ready = 1'b0;
    pulse(16'h0011);
    pulse(16'h0022);
    pulse(16'h0033);
    pulse(16'h0044);
    check("hold_sum", 32'(out_sum), 32'h0000AA);
    #2 reset = 1'b1;
    #1;
    check("areset_valid",    32'(out_valid), 32'd0);
    check("areset_sum",      32'(out_sum),   32'd0);
    check("areset_ovf",      32'(out_ovf),   32'd0);
    check("areset_in_ready", 32'(in_ready),  32'd1);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    pulse(16'h0000);
    pulse(16'h0005);
    pulse(16'h0006);
    check("zero_no_early_valid", 32'(out_valid), 32'd0);
    pulse(16'h0007);
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_sum",   32'(out_sum),   32'h000012);
    @(negedge clk);

    // Drop counter saturates at 255
    out_ready = 1'b0;
    pulse(16'h0001);
    pulse(16'h0001);
    pulse(16'h0001);
    pulse(16'h0001);
    burst(260, 16'h0001);
    check("drop_saturate", 32'(drop_cnt), 32'd255);
    check("drop_sum_kept", 32'(out_sum),  32'h000004);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
